// File: rtl/serial_adder_s_pkg.sv
// Shared definitions for the digit-serial adder/subtractor:
// FSM state encodings and digit/counter sizing helpers.
package serial_adder_s_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of digit cycles needed for one operation.
    function automatic int digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fulladder_s.sv
// One-bit full adder: two half-adder stages with an OR
// merging their carries.
module fulladder_s (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g1;
    logic g2;

    assign p  = a ^ b;
    assign g1 = a & b;
    assign s  = p ^ ci;
    assign g2 = p & ci;
    assign co = g1 | g2;

endmodule

// File: rtl/serial_adder_s.sv
// Digit-serial adder/subtractor: DIGIT full-adder cells reused
// over WIDTH/DIGIT cycles with one carry register between them.
module serial_adder_s
    import serial_adder_s_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = digits(WIDTH, DIGIT);
    localparam int CW = cnt_bits(N);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
            $error("serial_adder_s: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s_d;
    logic             last;

    // Operands shift right, so the active digit is always the low DIGIT bits.
    assign c[0] = carry;

    genvar i;
    generate
        for (i = 0; i < DIGIT; i++) begin : g_cell
            fulladder_s u_fa (
                .a  (op_a[i]),
                .b  (op_b[i]),
                .ci (c[i]),
                .s  (s_d[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    // New digit enters at the top; after N cycles acc holds the full sum.
    assign acc_next  = WIDTH'({s_d, acc} >> DIGIT);
    assign last      = (cnt == CW'(N - 1));
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // FSM, operand/carry datapath and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= c[DIGIT];
                    acc   <= acc_next;
                    if (last) begin
                        sum   <= acc_next;
                        cout  <= c[DIGIT];
                        ovf   <= c[DIGIT] ^ c[DIGIT-1];
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder_s.md
# serial_adder_s

Parametrised multi-cycle adder/subtractor that processes two WIDTH-bit operands DIGIT bits per clock, rippling one carry register between cycles. It trades latency for area: only DIGIT full-adder cells exist, regardless of WIDTH. Operands enter and results leave through valid/ready handshakes. It sits in the arithmetic datapath wherever a full-width combinational adder is too large.

## Interface
- WIDTH, 8: operand and result width; must be at least 2.
- DIGIT, 1: bits added per cycle; WIDTH % DIGIT == 0 is required, otherwise elaboration fails.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand set offered.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (sub=0) or borrow-in (sub=1).
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of MSB; for subtract, 1 means no borrow.
- ovf  out  1  signed (two's-complement) overflow.

## Operation
- N = WIDTH/DIGIT digits. FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a; latch b, or ~b when sub=1.
  - Initial carry = cin when sub=0, else !cin.
  - Digit counter = 0; go to RUN.
- RUN:
  - Each cycle adds digit cnt (bits cnt·DIGIT .. cnt·DIGIT+DIGIT−1) through a DIGIT-cell ripple chain.
  - Stores the DIGIT sum bits and updates the carry register.
  - When cnt = N−1: register sum, cout (final carry), and ovf (carry into MSB XOR carry out of MSB); go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; sum/cout/ovf held stable.
  - On out_valid&out_ready: go to IDLE.
  - in_ready=0, so no accept is possible in the same cycle.
- sum/cout/ovf keep their last result value in IDLE and RUN. They change only on the RUN→DONE edge.
- in_valid is ignored outside IDLE. a/b/cin/sub are sampled only on the accept edge.
- Reset (rst_n low at a clock edge, from any state, including mid-RUN):
  - State returns to IDLE; the operation in progress is discarded.
  - Counter, carry and operand registers cleared.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after the reset edge with rst_n high.

## Timing
- Accept edge = T. out_valid rises after edge T+N and stays high until the out_ready handshake edge.
- Latency, accept to out_valid: N cycles. DIGIT=WIDTH gives a 1-cycle registered adder.
- in_ready returns one cycle after the result handshake.
- Throughput: one operation per N+2 cycles when out_ready is held high.
- in_ready and out_valid are decoded from state registers only. There is no combinational path from any input to any output.
- Carry register wraps naturally; the counter wraps to 0 on RUN exit.

## Structure
- Shared arithmetic package holds:
  - FSM state typedef (IDLE/RUN/DONE).
  - localparam N and counter width $clog2(N), minimum 1.
- One sub-module: fulladder_s, a 1-bit full adder built from two half-adder stages plus an OR for carry. It is instantiated DIGIT times in a generate loop for the ripple chain.
- Everything else (FSM, operand shift/select, result capture) lives in serial_adder_s.

## Test plan
- WIDTH=8, DIGIT=1, a=0x35, b=0x4A, cin=0, sub=0:
  - sum=0x7F, cout=0, ovf=0.
  - out_valid rises exactly 8 cycles after accept.
- Carry and overflow cases:
  - a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
  - a=0x7F, b=0x00, cin=1 → sum=0x80, ovf=1.
- Subtract cases:
  - a=0x10, b=0x20, sub=1, cin=0 → sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
  - a=0x05, b=0x05, sub=1, cin=1 → sum=0xFF, cout=0.
- Backpressure:
  - out_ready low for 5 cycles in DONE → sum/cout/ovf stable, in_ready=0, and a pulsed in_valid with new operands is ignored.
  - Handshake → in_ready=1 the next cycle; the next operation gives its own correct result.
- Reset mid-RUN:
  - rst_n low for one edge after 3 digits → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 the next cycle.
  - A fresh op, 0x35+0x4A, gives 0x7F with 8-cycle latency.
- Parameter sweep: DIGIT=4 (latency 2) and DIGIT=8 (latency 1), plus WIDTH=16/DIGIT=4 random sub/cin vectors, all matched against a golden a±b±cin model.
